// File: rtl/fault_seq_pkg.sv
// Shared state encoding and default parameters for the fault shutdown sequencer.
// The state values double as the status readback encoding.
package fault_seq_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        RAMP_DOWN = 3'd1,
        HOLD      = 3'd2,
        RAMP_UP   = 3'd3,
        LOCKOUT   = 3'd4
    } seq_state_t;

    localparam int DEF_GAIN_W      = 16;
    localparam int DEF_RAMP_STEP   = 256;
    localparam int DEF_HOLD_CYCLES = 1024;
    localparam int DEF_MAX_FAULTS  = 4;

endpackage

// File: rtl/gain_slew.sv
// Moves a gain word one step toward a target, landing exactly on the target.
// The gap is measured in GAIN_W+1 bits so the step comparison never wraps.
module gain_slew #(
    parameter int GAIN_W = 16
) (
    input  logic [GAIN_W-1:0] current,
    input  logic [GAIN_W-1:0] target,
    input  logic [GAIN_W:0]   step,
    output logic [GAIN_W-1:0] next_gain
);

    logic [GAIN_W:0] cur_w;
    logic [GAIN_W:0] tgt_w;
    logic [GAIN_W:0] gap;

    // A full step is only taken when the gap exceeds it, so the result stays in range.
    always_comb begin
        cur_w     = {1'b0, current};
        tgt_w     = {1'b0, target};
        gap       = '0;
        next_gain = current;
        if (cur_w < tgt_w) begin
            gap       = tgt_w - cur_w;
            next_gain = (gap <= step) ? target : GAIN_W'(cur_w + step);
        end else if (cur_w > tgt_w) begin
            gap       = cur_w - tgt_w;
            next_gain = (gap <= step) ? target : GAIN_W'(cur_w - step);
        end
    end

endmodule

// File: rtl/fault_shutdown_sequencer.sv
// Ramps the AM carrier gain down on watchdog faults, holds it muted, then soft-starts it again.
// Repeated faults latch a lockout that only an operator clear releases.
module fault_shutdown_sequencer
    import fault_seq_pkg::*;
#(
    parameter int GAIN_W      = DEF_GAIN_W,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int MAX_FAULTS  = DEF_MAX_FAULTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              force_reset,
    input  logic              warning,
    input  logic              fault_clear,
    output logic [GAIN_W-1:0] gain_out,
    output logic              muted,
    output logic              lockout,
    output logic [3:0]        fault_count,
    output logic [2:0]        state
);

    localparam int                STEP_W      = GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_MAX    = {GAIN_W{1'b1}};
    localparam logic [GAIN_W-1:0] DUCK        = GAIN_MAX >> 1;
    localparam logic [GAIN_W:0]   STEP        = STEP_W'(RAMP_STEP);
    localparam int                HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    seq_state_t        state_q;
    logic [GAIN_W-1:0] gain_q;
    logic [3:0]        count_q;
    logic [3:0]        count_inc;
    logic [HOLD_W-1:0] hold_q;
    logic              force_q;
    logic              fault_evt;
    logic              hit_lockout;
    logic [GAIN_W-1:0] run_target;
    logic [GAIN_W-1:0] slew_target;
    logic [GAIN_W-1:0] slew_next;

    // A fault drags the slew target to zero in the same cycle it is seen.
    always_comb begin
        fault_evt   = force_reset & ~force_q;
        count_inc   = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;
        hit_lockout = int'(count_inc) >= MAX_FAULTS;
        run_target  = warning ? DUCK : GAIN_MAX;
        slew_target = run_target;
        if (state_q == RAMP_DOWN || fault_evt) begin
            slew_target = '0;
        end
    end

    gain_slew #(
        .GAIN_W (GAIN_W)
    ) u_slew (
        .current   (gain_q),
        .target    (slew_target),
        .step      (STEP),
        .next_gain (slew_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            gain_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            force_q <= 1'b0;
        end else begin
            force_q <= force_reset;
            if (state_q == LOCKOUT) begin
                gain_q <= '0;
                if (fault_clear) begin
                    state_q <= HOLD;
                    count_q <= '0;
                    hold_q  <= HOLD_RELOAD;
                end
            end else if (fault_evt) begin
                count_q <= count_inc;
                if (hit_lockout) begin
                    state_q <= LOCKOUT;
                    gain_q  <= '0;
                end else if (state_q == HOLD) begin
                    hold_q <= HOLD_RELOAD;
                end else begin
                    gain_q <= slew_next;
                    if (slew_next == '0) begin
                        state_q <= HOLD;
                        hold_q  <= HOLD_RELOAD;
                    end else begin
                        state_q <= RAMP_DOWN;
                    end
                end
            end else begin
                if (fault_clear) begin
                    count_q <= '0;
                end
                unique case (state_q)
                    RUN: begin
                        gain_q <= slew_next;
                    end
                    RAMP_DOWN: begin
                        gain_q <= slew_next;
                        if (slew_next == '0) begin
                            state_q <= HOLD;
                            hold_q  <= HOLD_RELOAD;
                        end
                    end
                    HOLD: begin
                        // The first upward step is taken on the same edge that leaves HOLD.
                        if (hold_q == '0) begin
                            gain_q  <= slew_next;
                            state_q <= (slew_next == run_target) ? RUN : RAMP_UP;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    RAMP_UP: begin
                        gain_q <= slew_next;
                        if (slew_next == run_target) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        gain_q <= '0;
                    end
                endcase
            end
        end
    end

    assign gain_out    = gain_q;
    assign muted       = (gain_q == '0);
    assign lockout     = (state_q == LOCKOUT);
    assign fault_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fault_shutdown_sequencer.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations, a monitor checks them each cycle.
`timescale 1ns/1ps
module tb_fault_shutdown_sequencer;

    localparam logic [2:0] S_RUN       = 3'd0;
    localparam logic [2:0] S_RAMP_DOWN = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_RAMP_UP   = 3'd3;
    localparam logic [2:0] S_LOCKOUT   = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       force_reset = 1'b0;
    logic       warning = 1'b0;
    logic       fault_clear = 1'b0;
    logic [7:0] gain_out;
    logic       muted;
    logic       lockout;
    logic [3:0] fault_count;
    logic [2:0] state;

    typedef struct {
        int          cyc;
        logic [16:0] vec;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    fault_shutdown_sequencer #(
        .GAIN_W      (8),
        .RAMP_STEP   (64),
        .HOLD_CYCLES (4),
        .MAX_FAULTS  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .force_reset (force_reset),
        .warning     (warning),
        .fault_clear (fault_clear),
        .gain_out    (gain_out),
        .muted       (muted),
        .lockout     (lockout),
        .fault_count (fault_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] pack_exp(input logic [2:0] st, input logic [7:0] g, input logic [3:0] c);
        return {st, g, (g == 8'd0), (st == S_LOCKOUT), c};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {state, gain_out, muted, lockout, fault_count};
    endfunction

    task automatic check_vector(input string tag, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got st=%0d gain=%0d muted=%0b lock=%0b cnt=%0d, expected st=%0d gain=%0d muted=%0b lock=%0b cnt=%0d",
                     tag, act[16:14], act[13:6], act[5], act[4], act[3:0],
                     exp[16:14], exp[13:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic warn, input logic clr);
        @(negedge clk);
        force_reset = fr;
        warning     = warn;
        fault_clear = clr;
    endtask

    task automatic checkOutput(input logic [2:0] st, input logic [7:0] g, input logic [3:0] c, input string tag);
        exp_t e;
        e.cyc = cyc + 1;
        e.vec = pack_exp(st, g, c);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic fr, input logic warn, input logic clr,
                        input logic [2:0] st, input logic [7:0] g, input logic [3:0] c, input string tag);
        applyStimulus(fr, warn, clr);
        checkOutput(st, g, c, tag);
    endtask

    task automatic hold_seq(input int n, input logic [3:0] c, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, S_HOLD, 8'd0, c, tag);
    endtask

    task automatic ramp_up_seq(input logic [3:0] c, input string tag);
        step(1'b0, 1'b0, 1'b0, S_RAMP_UP, 8'd64, c, tag);
        step(1'b0, 1'b0, 1'b0, S_RAMP_UP, 8'd128, c, tag);
        step(1'b0, 1'b0, 1'b0, S_RAMP_UP, 8'd192, c, tag);
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, c, tag);
    endtask

    task automatic down_hold_seq(input logic [3:0] c, input string tag);
        step(1'b0, 1'b0, 1'b0, S_RAMP_DOWN, 8'd127, c, tag);
        step(1'b0, 1'b0, 1'b0, S_RAMP_DOWN, 8'd63, c, tag);
        hold_seq(4, c, tag);
    endtask

    // Monitor: every cycle the DUT presents a status word; compare it against any expectation due now.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check_vector(e.tag, dut_vec(), e.vec);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_vector("reset_idle", dut_vec(), pack_exp(S_RUN, 8'd0, 4'd0));

        // Soft start after reset release.
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput(S_RUN, 8'd64, 4'd0, "soft_start");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd128, 4'd0, "soft_start");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd192, 4'd0, "soft_start");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd0, "soft_start");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd0, "steady");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd0, "steady");

        // Single fault episode.
        step(1'b1, 1'b0, 1'b0, S_RAMP_DOWN, 8'd191, 4'd1, "fault1_down");
        down_hold_seq(4'd1, "fault1_hold");
        ramp_up_seq(4'd1, "fault1_up");

        // Warning ducking and recovery.
        step(1'b0, 1'b1, 1'b0, S_RUN, 8'd191, 4'd1, "duck");
        step(1'b0, 1'b1, 1'b0, S_RUN, 8'd127, 4'd1, "duck");
        step(1'b0, 1'b1, 1'b0, S_RUN, 8'd127, 4'd1, "duck_hold");
        step(1'b0, 1'b1, 1'b0, S_RUN, 8'd127, 4'd1, "duck_hold");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd191, 4'd1, "unduck");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd1, "unduck");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd1, "unduck");

        // Second episode, then third fault locks out.
        step(1'b1, 1'b0, 1'b0, S_RAMP_DOWN, 8'd191, 4'd2, "fault2_down");
        down_hold_seq(4'd2, "fault2_hold");
        ramp_up_seq(4'd2, "fault2_up");
        step(1'b1, 1'b0, 1'b0, S_LOCKOUT, 8'd0, 4'd3, "lockout_entry");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, S_LOCKOUT, 8'd0, 4'd3, "lockout_level");
        step(1'b0, 1'b0, 1'b0, S_LOCKOUT, 8'd0, 4'd3, "lockout_idle");
        step(1'b1, 1'b0, 1'b0, S_LOCKOUT, 8'd0, 4'd3, "lockout_edge_ignored");
        step(1'b0, 1'b0, 1'b0, S_LOCKOUT, 8'd0, 4'd3, "lockout_idle");

        // Operator clear releases lockout through a full hold.
        step(1'b0, 1'b0, 1'b1, S_HOLD, 8'd0, 4'd0, "clear_lockout");
        hold_seq(3, 4'd0, "clear_hold");
        ramp_up_seq(4'd0, "clear_up");

        // Fault beats a simultaneous clear, then async reset mid ramp-down.
        step(1'b1, 1'b0, 1'b0, S_RAMP_DOWN, 8'd191, 4'd1, "fault3_down");
        down_hold_seq(4'd1, "fault3_hold");
        ramp_up_seq(4'd1, "fault3_up");
        step(1'b1, 1'b0, 1'b1, S_RAMP_DOWN, 8'd191, 4'd2, "fault_wins_clear");
        step(1'b0, 1'b0, 1'b0, S_RAMP_DOWN, 8'd127, 4'd2, "fault_wins_down");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_vector("async_reset", dut_vec(), pack_exp(S_RUN, 8'd0, 4'd0));
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd0, 4'd0, "held_reset");
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput(S_RUN, 8'd64, 4'd0, "restart");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd128, 4'd0, "restart");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd192, 4'd0, "restart");
        step(1'b0, 1'b0, 1'b0, S_RUN, 8'd255, 4'd0, "restart");

        // Clear outside lockout only zeroes the count; a fault in HOLD reloads the hold.
        step(1'b1, 1'b0, 1'b0, S_RAMP_DOWN, 8'd191, 4'd1, "fault4_down");
        step(1'b0, 1'b0, 1'b1, S_RAMP_DOWN, 8'd127, 4'd0, "clear_in_ramp");
        step(1'b0, 1'b0, 1'b0, S_RAMP_DOWN, 8'd63, 4'd0, "clear_in_ramp");
        hold_seq(2, 4'd0, "hold_pre_fault");
        step(1'b1, 1'b0, 1'b0, S_HOLD, 8'd0, 4'd1, "fault_in_hold");
        hold_seq(3, 4'd1, "hold_reloaded");
        ramp_up_seq(4'd1, "final_up");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
